// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frame controller between an SPI slave byte interface and an
// on-chip register bus. Runs entirely on fclk.
//
// Each chip-select frame starts with a command byte {rw, addr[6:0]}; every
// later byte is a data byte. Write frames turn each data byte into a register
// write. Read frames prefetch register data into tx_byte so it is ready
// before the host clocks the next byte out.
//
// Optional feature: define SPI_REG_CTRL_AUTOINC_EN to advance reg_addr after
// every write and every read capture. Without it reg_addr holds the command
// address for the whole frame (FIFO-port access). All timing is identical.
//
// Ports:
//   fclk        in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   css         in   frame active while high, synchronous to fclk
//   rx_vld      in   one-cycle strobe, rx_byte holds a complete byte
//   rx_byte     in   received byte
//   tx_byte     out  byte the SPI slave shifts out next (registered)
//   reg_addr    out  register bus address (registered)
//   reg_wdata   out  register write data (registered)
//   reg_we      out  one-cycle write strobe
//   reg_re      out  one-cycle read strobe
//   reg_rdata   in   read data, valid exactly one fclk after reg_re
//   busy        out  high whenever the FSM is not idle
//   frame_done  out  one-cycle pulse after css falls if data bytes moved
//
// Handshake: rx_vld is a pure strobe with no back-pressure. A byte is taken
// only in the cycle rx_vld is high and only in CMD, WR or RD; in any other
// state, or when css is low in the same cycle, the byte is dropped.
// reg_we/reg_re are fire-and-forget strobes; the register bus never stalls.

module spi_reg_ctrl #(
  parameter int unsigned          ADDR_W      = 7,
  parameter int unsigned          DATA_W      = 8,
  parameter logic [DATA_W-1:0]    STATUS_BYTE = 8'hA5
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              css,
  input  logic              rx_vld,
  input  logic [DATA_W-1:0] rx_byte,
  output logic [DATA_W-1:0] tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WR     = 3'd2,
    RD_REQ = 3'd3,
    RD_CAP = 3'd4,
    RD     = 3'd5
  } state_t;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

  state_t            state;
  logic [DATA_W-1:0] byte_cnt;   // data bytes accepted in this frame, saturating

  assign busy = (state != IDLE);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_byte    <= STATUS_BYTE;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_done <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_done <= 1'b0;

      if (state != IDLE && !css) begin
        // Frame end or abort: css wins over any byte arriving this cycle,
        // and any strobe that would have been raised is simply not raised.
        state      <= IDLE;
        tx_byte    <= STATUS_BYTE;
        frame_done <= (byte_cnt != '0);
        byte_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            tx_byte <= STATUS_BYTE;
            if (css) state <= CMD;
          end

          CMD: begin
            if (rx_vld) begin
              reg_addr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[DATA_W-1]) begin
                // reg_re is raised on entry so it is high for the whole
                // RD_REQ cycle with the freshly loaded address.
                state  <= RD_REQ;
                reg_re <= 1'b1;
              end else begin
                state <= WR;
              end
            end
          end

          WR: begin
            // Address moves the cycle after the strobe, so each write uses
            // the address that was current when its byte arrived.
            if (reg_we) reg_addr <= reg_addr + ADDR_STEP;
            if (rx_vld) begin
              reg_wdata <= rx_byte;
              reg_we    <= 1'b1;
              if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            end
          end

          RD_REQ: begin
            state <= RD_CAP;
          end

          RD_CAP: begin
            // reg_rdata answers the reg_re of the previous cycle.
            tx_byte  <= reg_rdata;
            reg_addr <= reg_addr + ADDR_STEP;
            state    <= RD;
          end

          RD: begin
            // Host has clocked out tx_byte; fetch the next one.
            if (rx_vld) begin
              state  <= RD_REQ;
              reg_re <= 1'b1;
              if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: directed frames for the key scenarios plus
// randomized frames, checked against a frame-level reference model
// (address pointer arithmetic, expected write/read queues, register array).

module tb_spi_reg_ctrl;

  localparam logic [7:0] STATUS = 8'hA5;
`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic [6:0] STEP = 7'd1;
`else
  localparam logic [6:0] STEP = 7'd0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       fclk = 1'b0;
  logic       rst_n;
  logic       css;
  logic       rx_vld;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_done;

  always #5 fclk = ~fclk;

  spi_reg_ctrl dut (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .css        (css),
    .rx_vld     (rx_vld),
    .rx_byte    (rx_byte),
    .tx_byte    (tx_byte),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- reference model state ----------------
  logic [7:0]  regs [128];
  logic [14:0] exp_wr_q[$];   // {addr, data}
  logic [6:0]  exp_rd_q[$];
  logic [7:0]  frame_data [8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          fd_seen  = 0;
  int          fd_exp   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register bus responder: data one fclk after reg_re, junk otherwise.
  always @(posedge fclk) begin
    reg_rdata <= reg_re ? regs[reg_addr] : 8'($urandom);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge fclk) begin
    if (rst_n) begin
      if (reg_we || reg_re) check("we_re_excl", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        if (exp_wr_q.size() == 0) check("we_unexp", {25'd0, reg_addr}, 32'h1ff);
        else begin
          logic [14:0] e;
          e = exp_wr_q.pop_front();
          check("wr_addr", {25'd0, reg_addr}, {25'd0, e[14:8]});
          check("wr_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
        end
      end
      if (reg_re) begin
        if (exp_rd_q.size() == 0) check("re_unexp", {25'd0, reg_addr}, 32'h1ff);
        else check("rd_addr", {25'd0, reg_addr}, {25'd0, exp_rd_q.pop_front()});
      end
      if (frame_done) fd_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge fclk);
  endtask

  // Called at a negedge; rx_vld is high for exactly one rising edge.
  task automatic pulse_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_byte = b;
    @(negedge fclk);
    rx_vld  = 1'b0;
  endtask

  task automatic end_checks(input string tag, input int done_bytes);
    check({tag, "_fd"}, {31'd0, frame_done}, {31'd0, done_bytes > 0});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tx_idle"}, {24'd0, tx_byte}, {24'd0, STATUS});
    if (done_bytes > 0) fd_exp++;
    @(negedge fclk);
    check({tag, "_fd_once"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_wrq_empty"}, exp_wr_q.size(), 32'd0);
    check({tag, "_rdq_empty"}, exp_rd_q.size(), 32'd0);
  endtask

  // One frame: command byte plus n data bytes taken from frame_data.
  // abort_last drops css in the same cycle as the last data byte.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input int n,
                           input bit abort_last);
    logic [6:0] a;
    bit         rd;
    int         done_bytes;
    a = cmd[6:0];
    rd = cmd[7];
    done_bytes = 0;
    @(negedge fclk);
    css = 1'b1;
    idle_cycles($urandom_range(1, 3));
    if (rd) exp_rd_q.push_back(a);
    pulse_byte(cmd);
    if (rd) begin
      @(negedge fclk);
      check({tag, "_tx_early"}, {24'd0, tx_byte}, {24'd0, STATUS});
      @(negedge fclk);
      check({tag, "_tx_first"}, {24'd0, tx_byte}, {24'd0, regs[a]});
      a = a + STEP;
    end
    for (int i = 0; i < n; i++) begin
      idle_cycles($urandom_range(6, 10));
      if (abort_last && i == n - 1) begin
        rx_vld  = 1'b1;
        rx_byte = frame_data[i];
        css     = 1'b0;
        @(negedge fclk);
        rx_vld = 1'b0;
        end_checks({tag, "_abort"}, done_bytes);
        return;
      end
      if (!rd) exp_wr_q.push_back({a, frame_data[i]});
      else     exp_rd_q.push_back(a);
      pulse_byte(frame_data[i]);
      done_bytes++;
      if (rd) begin
        idle_cycles(2);
        check({tag, "_tx_next"}, {24'd0, tx_byte}, {24'd0, regs[a]});
      end
      a = a + STEP;
    end
    idle_cycles($urandom_range(4, 6));
    check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
    css = 1'b0;
    @(negedge fclk);
    end_checks(tag, done_bytes);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n   = 1'b0;
    css     = 1'b0;
    rx_vld  = 1'b0;
    rx_byte = 8'h00;
    for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    regs[8'h10] = 8'hC3;
    regs[8'h11] = 8'h3C;

    idle_cycles(3);
    check("rst_tx", {24'd0, tx_byte}, {24'd0, STATUS});
    check("rst_addr", {25'd0, reg_addr}, 32'd0);
    check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    check("rst_strobes", {29'd0, reg_we, reg_re, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Write burst
    frame_data[0] = 8'h11;
    frame_data[1] = 8'h22;
    run_frame("wr_burst", 8'h05, 2, 1'b0);

    // Read burst with prefetch
    frame_data[0] = 8'h00;
    run_frame("rd_burst", 8'h90, 1, 1'b0);

    // Address wrap
    frame_data[0] = 8'h5A;
    frame_data[1] = 8'hA5;
    run_frame("wrap", 8'h7F, 2, 1'b0);

    // Abort on a data byte, with and without an earlier completed byte
    frame_data[0] = 8'h77;
    frame_data[1] = 8'h88;
    run_frame("abort2", 8'h20, 2, 1'b1);
    run_frame("abort1", 8'h21, 1, 1'b1);
    run_frame("rd_abort", 8'hC0, 2, 1'b1);

    // Command-only frames
    run_frame("cmd_only", 8'h01, 0, 1'b0);
    run_frame("cmd_only_rd", 8'h85, 0, 1'b0);

    // Byte while idle is ignored
    @(negedge fclk);
    pulse_byte(8'h81);
    idle_cycles(3);
    check("idle_rx_busy", {31'd0, busy}, 32'd0);
    check("idle_rx_tx", {24'd0, tx_byte}, {24'd0, STATUS});

    // Host too fast: byte lands in RD_REQ and is ignored
    css = 1'b1;
    idle_cycles(2);
    exp_rd_q.push_back(7'h10);
    pulse_byte(8'h90);
    pulse_byte(8'hEE);
    @(negedge fclk);
    check("fast_tx", {24'd0, tx_byte}, {24'd0, regs[7'h10]});
    idle_cycles(4);
    css = 1'b0;
    @(negedge fclk);
    end_checks("fast", 0);

    // Reset mid-frame in WR
    css = 1'b1;
    idle_cycles(2);
    pulse_byte(8'h05);
    idle_cycles(6);
    exp_wr_q.push_back({7'h05, 8'h3E});
    pulse_byte(8'h3E);
    idle_cycles(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {24'd0, tx_byte}, {24'd0, STATUS});
    check("mid_rst_addr", {25'd0, reg_addr}, 32'd0);
    check("mid_rst_wdata", {24'd0, reg_wdata}, 32'd0);
    check("mid_rst_strobes", {29'd0, reg_we, reg_re, frame_done}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    idle_cycles(2);
    css   = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_fd", {31'd0, frame_done}, 32'd0);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      logic [7:0] cmd;
      int         n;
      bit         ab;
      cmd = 8'($urandom);
      n   = $urandom_range(0, 4);
      ab  = (n > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 8; i++) frame_data[i] = 8'($urandom);
      run_frame("rand", cmd, n, ab);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(3);
    check("fd_total", fd_seen, fd_exp);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
